// File: rtl/execute_flag_register_ckpt.sv
// Execute-stage condition flag register with fixed-priority source select and a
// LIFO checkpoint stack for single-cycle flag recovery on branch or exception flush.
module execute_flag_register_ckpt #(
    parameter int FLAG_W     = 5,
    parameter int NUM_SRC    = 4,
    parameter int CKPT_DEPTH = 4,
    localparam int CNT_W     = $clog2(CKPT_DEPTH + 1)
) (
    input  logic                      iCLOCK,
    input  logic                      inRESET,
    input  logic                      iRESET_SYNC,
    input  logic                      iCTRL_HOLD,
    input  logic                      iPFLAGR_VALID,
    input  logic [FLAG_W-1:0]         iPFLAGR,
    input  logic                      iPREV_INST_VALID,
    input  logic                      iPREV_BUSY,
    input  logic                      iPREV_FLAG_WRITE,
    input  logic [NUM_SRC-1:0]        iSRC_VALID,
    input  logic [NUM_SRC*FLAG_W-1:0] iSRC_FLAG,
    input  logic                      iCKPT_PUSH,
    input  logic                      iCKPT_POP,
    input  logic                      iCKPT_RESTORE,
    input  logic                      iERR_CLEAR,
    output logic [FLAG_W-1:0]         oFLAG,
    output logic                      oFLAG_CHANGED,
    output logic [CNT_W-1:0]          oCKPT_COUNT,
    output logic                      oCKPT_FULL,
    output logic                      oCKPT_EMPTY,
    output logic                      oCKPT_ERR
);

    localparam int IDX_W = (CKPT_DEPTH > 1) ? $clog2(CKPT_DEPTH) : 1;

    logic [FLAG_W-1:0] r_flag;
    logic              r_changed;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;
    logic [FLAG_W-1:0] r_stack [CKPT_DEPTH];

    logic              w_empty;
    logic              w_full;
    logic              w_restore;
    logic              w_push;
    logic              w_pop;
    logic              w_update;
    logic              w_src_hit;
    logic [FLAG_W-1:0] w_src_flag;
    logic [IDX_W-1:0]  w_top_idx;
    logic [IDX_W-1:0]  w_push_idx;
    logic [FLAG_W-1:0] w_flag_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_new_err;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(CKPT_DEPTH));
    assign w_restore  = iCKPT_RESTORE & ~w_empty;
    assign w_push     = iCKPT_PUSH & ~iCTRL_HOLD;
    assign w_pop      = iCKPT_POP & ~iCTRL_HOLD;
    assign w_update   = ~iPREV_BUSY & iPREV_INST_VALID & iPREV_FLAG_WRITE;
    assign w_top_idx  = IDX_W'(r_count - CNT_W'(1));
    assign w_push_idx = IDX_W'(r_count);

    // Descending scan so the lowest valid index is the last to assign and wins.
    always_comb begin
        w_src_hit  = 1'b0;
        w_src_flag = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (iSRC_VALID[k]) begin
                w_src_hit  = 1'b1;
                w_src_flag = iSRC_FLAG[k*FLAG_W +: FLAG_W];
            end
        end
    end

    always_comb begin
        w_flag_nxt = r_flag;
        if (w_restore) begin
            w_flag_nxt = r_stack[w_top_idx];
        end else if (iPFLAGR_VALID) begin
            w_flag_nxt = iPFLAGR;
        end else if (iCTRL_HOLD) begin
            w_flag_nxt = r_flag;
        end else if (w_update && w_src_hit) begin
            w_flag_nxt = w_src_flag;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        w_wr_en     = 1'b0;
        w_wr_idx    = w_push_idx;
        w_new_err   = 1'b0;
        if (w_restore) begin
            w_count_nxt = r_count - CNT_W'(1);
            w_new_err   = w_push | w_pop;
        end else begin
            w_new_err = iCKPT_RESTORE;
            if (w_push && w_pop) begin
                // Combined push+pop replaces the top in place; on an empty stack it is a push.
                w_wr_en = 1'b1;
                if (w_empty) begin
                    w_count_nxt = r_count + CNT_W'(1);
                end else begin
                    w_wr_idx = w_top_idx;
                end
            end else if (w_push) begin
                if (w_full) begin
                    w_new_err = 1'b1;
                end else begin
                    w_wr_en     = 1'b1;
                    w_count_nxt = r_count + CNT_W'(1);
                end
            end else if (w_pop) begin
                if (w_empty) begin
                    w_new_err = 1'b1;
                end else begin
                    w_count_nxt = r_count - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_flag    <= '0;
            r_changed <= 1'b0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else if (iRESET_SYNC) begin
            r_flag    <= '0;
            r_changed <= 1'b0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_flag    <= w_flag_nxt;
            r_changed <= (w_flag_nxt != r_flag);
            r_count   <= w_count_nxt;
            if (w_new_err) begin
                r_err <= 1'b1;
            end else if (iERR_CLEAR) begin
                r_err <= 1'b0;
            end
        end
    end

    // Stack storage carries no reset; entries above the count are never read.
    always_ff @(posedge iCLOCK) begin
        if (inRESET && !iRESET_SYNC && w_wr_en) begin
            r_stack[w_wr_idx] <= r_flag;
        end
    end

    assign oFLAG         = r_flag;
    assign oFLAG_CHANGED = r_changed;
    assign oCKPT_COUNT   = r_count;
    assign oCKPT_FULL    = w_full;
    assign oCKPT_EMPTY   = w_empty;
    assign oCKPT_ERR     = r_err;

endmodule

// File: tb/tb_execute_flag_register_ckpt.sv
// Directed, table-driven bench for execute_flag_register_ckpt with hand-computed expectations.
module tb_execute_flag_register_ckpt;

    localparam int FLAG_W     = 5;
    localparam int NUM_SRC    = 4;
    localparam int CKPT_DEPTH = 4;
    localparam int CNT_W      = $clog2(CKPT_DEPTH + 1);

    logic                      clk;
    logic                      rst_n;
    logic                      rst_sync;
    logic                      hold;
    logic                      pf_valid;
    logic [FLAG_W-1:0]         pf;
    logic                      inst_valid;
    logic                      busy;
    logic                      fwrite;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*FLAG_W-1:0] src_flag;
    logic                      push;
    logic                      pop;
    logic                      restore;
    logic                      err_clr;
    logic [FLAG_W-1:0]         flag;
    logic                      changed;
    logic [CNT_W-1:0]          count;
    logic                      full;
    logic                      empty;
    logic                      err;

    int checks = 0;
    int errors = 0;

    execute_flag_register_ckpt #(
        .FLAG_W    (FLAG_W),
        .NUM_SRC   (NUM_SRC),
        .CKPT_DEPTH(CKPT_DEPTH)
    ) dut (
        .iCLOCK          (clk),
        .inRESET         (rst_n),
        .iRESET_SYNC     (rst_sync),
        .iCTRL_HOLD      (hold),
        .iPFLAGR_VALID   (pf_valid),
        .iPFLAGR         (pf),
        .iPREV_INST_VALID(inst_valid),
        .iPREV_BUSY      (busy),
        .iPREV_FLAG_WRITE(fwrite),
        .iSRC_VALID      (src_valid),
        .iSRC_FLAG       (src_flag),
        .iCKPT_PUSH      (push),
        .iCKPT_POP       (pop),
        .iCKPT_RESTORE   (restore),
        .iERR_CLEAR      (err_clr),
        .oFLAG           (flag),
        .oFLAG_CHANGED   (changed),
        .oCKPT_COUNT     (count),
        .oCKPT_FULL      (full),
        .oCKPT_EMPTY     (empty),
        .oCKPT_ERR       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hold;
        logic        pv;
        logic [4:0]  pf;
        logic        upd;
        logic        busy;
        logic [3:0]  sv;
        logic [19:0] sf;
        logic        push;
        logic        pop;
        logic        rst;
        logic        ec;
        logic [4:0]  e_flag;
        logic        e_ch;
        logic [2:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic h, logic pv, logic [4:0] pfv, logic upd, logic bsy,
                                logic [3:0] sv, logic [19:0] sf, logic pu, logic po,
                                logic rs, logic ec, logic [4:0] ef, logic ech,
                                logic [2:0] ecnt, logic eerr);
        vec_t v;
        v.hold = h; v.pv = pv; v.pf = pfv; v.upd = upd; v.busy = bsy; v.sv = sv; v.sf = sf;
        v.push = pu; v.pop = po; v.rst = rs; v.ec = ec;
        v.e_flag = ef; v.e_ch = ech; v.e_cnt = ecnt; v.e_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_state(input int idx, input logic [4:0] ef, input logic ech,
                             input logic [2:0] ecnt, input logic eerr);
        chk("flag", idx, 32'(flag), 32'(ef));
        chk("changed", idx, 32'(changed), 32'(ech));
        chk("count", idx, 32'(count), 32'(ecnt));
        chk("err", idx, 32'(err), 32'(eerr));
        chk("full", idx, 32'(full), 32'(ecnt == 3'(CKPT_DEPTH)));
        chk("empty", idx, 32'(empty), 32'(ecnt == 3'd0));
    endtask

    task automatic idle();
        rst_sync = 0; hold = 0; pf_valid = 0; pf = '0; inst_valid = 0; busy = 0; fwrite = 0;
        src_valid = '0; src_flag = '0; push = 0; pop = 0; restore = 0; err_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Brings the DUT to count=3, oFLAG=5'h12, ERR=1 from any state.
    task automatic build_state();
        idle();
        rst_sync = 1; tick();
        idle();
        pf_valid = 1; pf = 5'h12; push = 1; tick();
        pf_valid = 0; tick(); tick(); tick();
        tick();
        push = 0; pop = 1; tick();
        idle();
        chk("pre_cnt", 0, 32'(count), 32'd3);
        chk("pre_flag", 0, 32'(flag), 32'h12);
        chk("pre_err", 0, 32'(err), 32'd1);
    endtask

    localparam logic [19:0] SF_A = {5'h1C, 5'h00, 5'h03, 5'h00};
    localparam logic [19:0] SF_B = {5'h00, 5'h00, 5'h00, 5'h0F};
    localparam logic [19:0] SF_C = {5'h00, 5'h00, 5'h00, 5'h0A};
    localparam logic [19:0] SF_D = {5'h00, 5'h1F, 5'h00, 5'h00};

    initial begin
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_state(-1, 5'h00, 0, 3'd0, 0);
        rst_n = 1;
        tick();

        //           h  pv pf     up bsy sv       sf    pu po rs ec  flag   ch cnt err
        vecs.push_back(mk(0, 0, 5'h00, 1, 0, 4'b1010, SF_A, 0, 0, 0, 0, 5'h03, 1, 0, 0));
        vecs.push_back(mk(0, 0, 5'h00, 1, 0, 4'b1010, SF_A, 0, 0, 0, 0, 5'h03, 0, 0, 0));
        vecs.push_back(mk(1, 0, 5'h00, 1, 0, 4'b0001, SF_B, 0, 0, 0, 0, 5'h03, 0, 0, 0));
        vecs.push_back(mk(1, 1, 5'h11, 1, 0, 4'b0001, SF_B, 0, 0, 0, 0, 5'h11, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5'h05, 0, 0, 4'b0000, '0,   0, 0, 0, 0, 5'h05, 1, 0, 0));
        vecs.push_back(mk(0, 0, 5'h00, 0, 0, 4'b0000, '0,   1, 0, 0, 0, 5'h05, 0, 1, 0));
        vecs.push_back(mk(0, 0, 5'h00, 1, 0, 4'b0001, SF_C, 0, 0, 0, 0, 5'h0A, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'h00, 1, 0, 4'b0100, SF_D, 1, 0, 0, 0, 5'h1F, 1, 2, 0));
        vecs.push_back(mk(0, 0, 5'h00, 0, 0, 4'b0000, '0,   0, 0, 1, 0, 5'h0A, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'h00, 0, 0, 4'b0000, '0,   0, 0, 1, 0, 5'h05, 1, 0, 0));
        vecs.push_back(mk(0, 0, 5'h00, 1, 0, 4'b0000, SF_A, 0, 0, 0, 0, 5'h05, 0, 0, 0));
        vecs.push_back(mk(0, 0, 5'h00, 1, 1, 4'b0001, SF_B, 0, 0, 0, 0, 5'h05, 0, 0, 0));
        // Overflow: fifth push is dropped, stacked values are 05,01,02,03.
        vecs.push_back(mk(0, 1, 5'h01, 0, 0, 4'b0000, '0,   1, 0, 0, 0, 5'h01, 1, 1, 0));
        vecs.push_back(mk(0, 1, 5'h02, 0, 0, 4'b0000, '0,   1, 0, 0, 0, 5'h02, 1, 2, 0));
        vecs.push_back(mk(0, 1, 5'h03, 0, 0, 4'b0000, '0,   1, 0, 0, 0, 5'h03, 1, 3, 0));
        vecs.push_back(mk(0, 1, 5'h04, 0, 0, 4'b0000, '0,   1, 0, 0, 0, 5'h04, 1, 4, 0));
        vecs.push_back(mk(0, 1, 5'h1E, 0, 0, 4'b0000, '0,   1, 0, 0, 0, 5'h1E, 1, 4, 1));
        vecs.push_back(mk(0, 0, 5'h00, 0, 0, 4'b0000, '0,   0, 0, 0, 1, 5'h1E, 0, 4, 0));
        vecs.push_back(mk(0, 0, 5'h00, 0, 0, 4'b0000, '0,   0, 0, 1, 0, 5'h03, 1, 3, 0));
        vecs.push_back(mk(0, 0, 5'h00, 0, 0, 4'b0000, '0,   0, 1, 0, 0, 5'h03, 0, 2, 0));
        vecs.push_back(mk(0, 0, 5'h00, 0, 0, 4'b0000, '0,   0, 1, 0, 0, 5'h03, 0, 1, 0));
        vecs.push_back(mk(0, 0, 5'h00, 0, 0, 4'b0000, '0,   0, 1, 0, 0, 5'h03, 0, 0, 0));
        vecs.push_back(mk(0, 0, 5'h00, 0, 0, 4'b0000, '0,   0, 1, 0, 0, 5'h03, 0, 0, 1));
        vecs.push_back(mk(0, 0, 5'h00, 0, 0, 4'b0000, '0,   0, 0, 0, 1, 5'h03, 0, 0, 0));
        // Conflicts.
        vecs.push_back(mk(0, 1, 5'h06, 0, 0, 4'b0000, '0,   0, 0, 0, 0, 5'h06, 1, 0, 0));
        vecs.push_back(mk(0, 1, 5'h07, 0, 0, 4'b0000, '0,   1, 0, 0, 0, 5'h07, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5'h00, 0, 0, 4'b0000, '0,   1, 0, 0, 0, 5'h07, 0, 2, 0));
        vecs.push_back(mk(0, 1, 5'h15, 0, 0, 4'b0000, '0,   0, 0, 0, 0, 5'h15, 1, 2, 0));
        vecs.push_back(mk(0, 0, 5'h00, 0, 0, 4'b0000, '0,   1, 0, 1, 0, 5'h07, 1, 1, 1));
        vecs.push_back(mk(0, 1, 5'h19, 0, 0, 4'b0000, '0,   0, 0, 0, 0, 5'h19, 1, 1, 1));
        vecs.push_back(mk(0, 0, 5'h00, 0, 0, 4'b0000, '0,   1, 1, 0, 0, 5'h19, 0, 1, 1));
        vecs.push_back(mk(0, 0, 5'h00, 0, 0, 4'b0000, '0,   0, 0, 1, 0, 5'h19, 0, 0, 1));
        vecs.push_back(mk(0, 0, 5'h00, 0, 0, 4'b0000, '0,   0, 0, 0, 1, 5'h19, 0, 0, 0));
        vecs.push_back(mk(0, 1, 5'h08, 0, 0, 4'b0000, '0,   0, 0, 1, 0, 5'h08, 1, 0, 1));
        vecs.push_back(mk(0, 0, 5'h00, 0, 0, 4'b0000, '0,   0, 1, 0, 1, 5'h08, 0, 0, 1));
        vecs.push_back(mk(0, 0, 5'h00, 0, 0, 4'b0000, '0,   0, 0, 0, 1, 5'h08, 0, 0, 0));
        vecs.push_back(mk(1, 0, 5'h00, 0, 0, 4'b0000, '0,   0, 1, 0, 0, 5'h08, 0, 0, 0));
        vecs.push_back(mk(0, 1, 5'h0C, 0, 0, 4'b0000, '0,   1, 1, 0, 0, 5'h0C, 1, 1, 0));
        vecs.push_back(mk(1, 0, 5'h00, 0, 0, 4'b0000, '0,   0, 0, 1, 0, 5'h08, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            hold = vecs[i].hold; pf_valid = vecs[i].pv; pf = vecs[i].pf;
            inst_valid = vecs[i].upd; fwrite = vecs[i].upd; busy = vecs[i].busy;
            src_valid = vecs[i].sv; src_flag = vecs[i].sf;
            push = vecs[i].push; pop = vecs[i].pop; restore = vecs[i].rst;
            err_clr = vecs[i].ec;
            tick();
            chk_state(i, vecs[i].e_flag, vecs[i].e_ch, vecs[i].e_cnt, vecs[i].e_err);
        end
        idle();

        // Asynchronous reset between edges takes effect immediately.
        build_state();
        #3 rst_n = 0;
        #1;
        chk_state(100, 5'h00, 0, 3'd0, 0);
        #2 rst_n = 1;
        tick();
        chk_state(101, 5'h00, 0, 3'd0, 0);

        // Synchronous clear at an edge.
        build_state();
        rst_sync = 1;
        tick();
        rst_sync = 0;
        chk_state(102, 5'h00, 0, 3'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
